// File: rtl/const_arb_if.sv
// Request/acknowledge bundle between two constant requesters and the shared lookup arbiter.
interface const_arb_if;
  logic       req0;
  logic [2:0] idx0;
  logic       req1;
  logic [2:0] idx1;
  logic       ack0;
  logic       ack1;
  logic [7:0] rdata;
  logic [7:0] served;
  logic       busy;

  modport master (
    output req0, idx0, req1, idx1,
    input  ack0, ack1, rdata, served, busy
  );

  modport slave (
    input  req0, idx0, req1, idx1,
    output ack0, ack1, rdata, served, busy
  );
endinterface

// File: rtl/const_arb.sv
// Round-robin arbiter for two requesters sharing an 8-entry constant table; ack one cycle
// after the lookup edge, next acceptance 3 edges later. Requesters hold req until ack.
module const_arb (
  input  logic        clk,
  input  logic        rst,
  const_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  localparam logic [2:0] NARROW5  = 3'b101;
  localparam logic [8:0] WIDE345  = 9'd345;

  state_t     state;
  logic       win;
  logic [2:0] idx_q;
  logic       last;
  logic       ack0_q;
  logic       ack1_q;
  logic [7:0] rdata_q;
  logic [7:0] served_q;

  function automatic logic [7:0] lookup(input logic [2:0] i);
    logic [7:0] v;
    case (i)
      3'd0:    v = 8'd1;
      3'd1:    v = 8'd0;
      3'd2:    v = {5'd0, NARROW5};
      3'd3:    v = 8'd101;
      3'd4:    v = 8'd5;
      3'd5:    v = WIDE345[7:0];
      3'd6:    v = 8'hFF;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      win      <= 1'b0;
      idx_q    <= 3'd0;
      last     <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata_q  <= 8'h00;
      served_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          // On contention the requester that did not win last time takes the grant.
          if (bus.req0 && bus.req1) begin
            win   <= ~last;
            idx_q <= last ? bus.idx0 : bus.idx1;
            state <= LOOKUP;
          end else if (bus.req0) begin
            win   <= 1'b0;
            idx_q <= bus.idx0;
            state <= LOOKUP;
          end else if (bus.req1) begin
            win   <= 1'b1;
            idx_q <= bus.idx1;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          rdata_q <= lookup(idx_q);
          ack0_q  <= ~win;
          ack1_q  <= win;
          state   <= RESP;
        end
        RESP: begin
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          served_q <= served_q + 8'd1;
          last     <= win;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.rdata  = rdata_q;
  assign bus.served = served_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_const_arb.sv
// Directed and randomized checks of const_arb against a transaction-level model.
module tb_const_arb;

  logic clk = 1'b0;
  logic rst;
  const_arb_if bus ();

  const_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: table contents, last winner, grant count.
  int tbl [8];
  int m_last;
  int m_served;

  bit       r0, r1;
  logic [2:0] i0, i1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req0 = r0;
    bus.idx0 = i0;
    bus.req1 = r1;
    bus.idx1 = i1;
  endtask

  task automatic model_reset();
    m_last   = 1;
    m_served = 0;
  endtask

  // Called at a negedge with the DUT idle; the next rising edge must accept.
  task automatic grant(input string tag, input bit drop, input int new_idx1);
    int who;
    logic [7:0] dexp;
    drive();
    if (r0 && r1) who = (m_last == 1) ? 0 : 1;
    else          who = r0 ? 0 : 1;
    dexp = 8'(tbl[(who == 0) ? int'(i0) : int'(i1)]);
    @(negedge clk);
    chk({tag, "_busy_lookup"}, {7'd0, bus.busy}, 8'd1);
    chk({tag, "_early_ack"}, {6'd0, bus.ack1, bus.ack0}, 8'd0);
    if (new_idx1 >= 0) begin
      i1 = 3'(new_idx1);
      drive();
    end
    @(negedge clk);
    chk({tag, "_ack0"}, {7'd0, bus.ack0}, (who == 0) ? 8'd1 : 8'd0);
    chk({tag, "_ack1"}, {7'd0, bus.ack1}, (who == 1) ? 8'd1 : 8'd0);
    chk({tag, "_rdata"}, bus.rdata, dexp);
    chk({tag, "_busy_resp"}, {7'd0, bus.busy}, 8'd1);
    m_last   = who;
    m_served = (m_served + 1) % 256;
    if (drop) begin
      if (who == 0) r0 = 1'b0;
      else          r1 = 1'b0;
      drive();
    end
    @(negedge clk);
    chk({tag, "_ack_drop"}, {6'd0, bus.ack1, bus.ack0}, 8'd0);
    chk({tag, "_served"}, bus.served, 8'(m_served));
    chk({tag, "_idle"}, {7'd0, bus.busy}, 8'd0);
    chk({tag, "_rdata_hold"}, bus.rdata, dexp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0] = 1;
    tbl[1] = 0;
    tbl[2] = 5;
    tbl[3] = 101;
    tbl[4] = 5;
    tbl[5] = 345 % 256;
    tbl[6] = 255;
    tbl[7] = 0;
    model_reset();

    r0 = 1'b0; r1 = 1'b0; i0 = 3'd0; i1 = 3'd0;
    drive();
    rst = 1'b1;
    #1;
    chk("rst_acks", {6'd0, bus.ack1, bus.ack0}, 8'd0);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_served", bus.served, 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, idx 5 -> 89.
    r0 = 1'b1; i0 = 3'd5;
    grant("single", 1'b1, -1);
    chk("single_rdata89", bus.rdata, 8'd89);

    // Simultaneous requests after reset: requester 0 first.
    do_reset();
    r0 = 1'b1; i0 = 3'd3; r1 = 1'b1; i1 = 3'd2;
    grant("sim_a", 1'b1, -1);
    grant("sim_b", 1'b1, -1);
    chk("sim_served2", bus.served, 8'd2);

    // Continuous contention: alternation with exact 3-cycle spacing.
    r0 = 1'b1; r1 = 1'b1;
    i0 = 3'($urandom_range(0, 7));
    i1 = 3'($urandom_range(0, 7));
    for (int k = 0; k < 4; k++) grant("contend", 1'b0, -1);

    // idx change during LOOKUP must not alter the result.
    r0 = 1'b0; r1 = 1'b0;
    drive();
    @(negedge clk);
    r1 = 1'b1; i1 = 3'd6;
    grant("idxchg", 1'b1, 0);

    // Reset during LOOKUP: no ack, outputs clear immediately.
    r0 = 1'b1; i0 = 3'd6;
    drive();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstlk_acks", {6'd0, bus.ack1, bus.ack0}, 8'd0);
    chk("rstlk_rdata", bus.rdata, 8'h00);
    chk("rstlk_served", bus.served, 8'h00);
    chk("rstlk_busy", {7'd0, bus.busy}, 8'd0);
    @(negedge clk);
    chk("rstlk_noack", {6'd0, bus.ack1, bus.ack0}, 8'd0);
    rst = 1'b0;
    model_reset();
    grant("post_rst", 1'b1, -1);

    // Reset during RESP withdraws the ack at once.
    r1 = 1'b1; i1 = 3'd3;
    drive();
    @(negedge clk);
    @(negedge clk);
    chk("rstrs_ack_before", {7'd0, bus.ack1}, 8'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstrs_ack_cleared", {6'd0, bus.ack1, bus.ack0}, 8'd0);
    chk("rstrs_served", bus.served, 8'h00);
    r1 = 1'b0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      if (!r0 && !r1) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("rnd_gap_idle", {7'd0, bus.busy}, 8'd0);
        end
      end
      if (!r0 && $urandom_range(0, 1) == 1) begin
        r0 = 1'b1; i0 = 3'($urandom_range(0, 7));
      end
      if (!r1 && $urandom_range(0, 1) == 1) begin
        r1 = 1'b1; i1 = 3'($urandom_range(0, 7));
      end
      if (!r0 && !r1) begin
        r0 = 1'b1; i0 = 3'($urandom_range(0, 7));
      end
      grant("rnd", 1'($urandom_range(0, 1)), -1);
    end

    // Served counter wraps after 256 grants.
    r0 = 1'b0; r1 = 1'b0;
    drive();
    do_reset();
    for (int k = 0; k < 256; k++) begin
      r0 = 1'b1; i0 = 3'($urandom_range(0, 7));
      grant("wrap", 1'b1, -1);
    end
    chk("wrap_zero", bus.served, 8'd0);
    r1 = 1'b1; i1 = 3'd5;
    grant("wrap_next", 1'b1, -1);
    chk("wrap_one", bus.served, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/const_arb.md
CONST_ARB -- requirements
Module: const_arb

Interface
REQ-001 Ports (name  direction  width  meaning):
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 wants a constant; level, held until ack0.
REQ-005 idx0  input  3  requester 0 table index; stable while req0 high.
REQ-006 req1  input  1  requester 1 request; same rules as req0.
REQ-007 idx1  input  3  requester 1 table index.
REQ-008 ack0  output  1  one-cycle pulse: rdata is valid for requester 0.
REQ-009 ack1  output  1  one-cycle pulse: rdata is valid for requester 1.
REQ-010 rdata  output  8  shared constant result, registered.
REQ-011 served  output  8  count of completed grants, modulo 256.
REQ-012 busy  output  1  high when state is not IDLE.

Function
REQ-013 Shared resource: fixed 8-entry constant table, 8-bit entries; idx 0..7 = 1, 0, 3'b101 (=5), 8'd101, 5, 345 truncated to 8 bits (=89), 8'hFF, 8'h00.
REQ-014 Table entries narrower than 8 bits zero-extend; wider entries keep the low 8 bits only.
REQ-015 FSM states: IDLE, LOOKUP, RESP; reset state IDLE.
REQ-016 IDLE: if req0 or req1 high at the edge, register the winner and its idx, then go to LOOKUP; otherwise stay in IDLE.
REQ-017 LOOKUP: at the edge, rdata <= table[registered idx], the winner's ack goes high, and the FSM goes to RESP.
REQ-018 RESP: the winner's ack is high for exactly this one cycle; at the edge, ack drops, served increments, the last-grant pointer is set to the winner, and the FSM goes to IDLE.
REQ-019 Latency: request accepted at edge E; ack and rdata valid in the cycle after edge E+1; earliest next acceptance at edge E+3.
REQ-020 Requests are sampled only in IDLE; req levels during LOOKUP/RESP are ignored.
REQ-021 Arbitration when only one request is high: grant that requester.
REQ-022 Arbitration when both are high: grant the requester that is not the last-grant pointer (round-robin).
REQ-023 Round-robin ties: the pointer resets to 1, so requester 0 wins the first tie.
REQ-024 idx is captured at acceptance; changing idx after acceptance does not alter rdata.
REQ-025 ack0 and ack1 are never high in the same cycle.
REQ-026 rdata holds its last value between acks; it is not cleared.
REQ-027 served wraps from 255 to 0 with no saturation or flag.
REQ-028 A requester that keeps req high after its ack is re-eligible in the next IDLE and is still subject to round-robin.
REQ-029 busy is combinational from state: 0 in IDLE, 1 in LOOKUP and RESP.

Reset
REQ-030 When rst is high, immediately and independent of clk: state=IDLE, ack0=0, ack1=0, rdata=8'h00, served=8'h00, last-grant pointer=1, captured winner/idx=0.
REQ-031 Reset mid-transaction (LOOKUP or RESP) abandons the grant: no ack is issued and served is not incremented.
REQ-032 After rst falls, the first rising edge with a request behaves as IDLE acceptance.

Verification
REQ-033 Single request: req0=1, idx0=5 -> ack0 pulses one cycle, 2 cycles after acceptance, rdata=89, served=1.
REQ-034 Simultaneous requests after reset: req0=req1=1, idx0=3, idx1=2, both held until ack -> first ack0 with rdata=101, then ack1 with rdata=5; served=2.
REQ-035 Continuous contention: both requests held high for 12 cycles -> acks alternate 0,1,0,1; each ack is 3 cycles apart; ack0/ack1 never overlap.
REQ-036 idx change after acceptance: accept idx1=6, change it to 0 during LOOKUP -> rdata=8'hFF.
REQ-037 Reset during LOOKUP: assert rst asynchronously -> outputs clear at once, no ack, served unchanged at 0.
REQ-038 Counter wrap: 256 grants -> served reads 0, and the next grant gives served=1.
